// File: rtl/insn_line_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction line cache.
package insn_line_cache_pkg;

   localparam int LINE_W     = 128;
   localparam int LINE_BYTES = 16;
   localparam int OFFSET_W   = $clog2(LINE_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_FILL   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/insn_line_cache_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, registered read (latency 1).
module insn_line_cache_sdp_ram #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   // NOTE: the storage array has no reset so it maps onto a RAM macro; line validity lives in flops elsewhere.
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge CLK) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/insn_line_cache.sv
// Direct-mapped L1 instruction line cache: 128-bit lines served to fetch, single-line fills from memory,
// per-line invalidate and full flush with poisoning of an in-flight fill.
module insn_line_cache
   import insn_line_cache_pkg::*;
#(
   parameter int LINES  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic              i_core_req,
   input  logic [ADDR_W-1:0] i_core_addr,
   input  logic              i_cacheable,
   output logic              o_core_ack,
   output logic [LINE_W-1:0] o_core_data,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [LINE_W-1:0] i_mem_data,
   input  logic              i_inv,
   input  logic [ADDR_W-1:0] i_inv_addr,
   input  logic              i_flush
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;
   localparam int TAG_LO = IDX_W + OFFSET_W;

   state_e                   r_state, w_state_next;
   logic [ADDR_W-1:OFFSET_W] r_line_addr;
   logic                     r_cacheable;
   logic                     r_poison;
   logic [LINES-1:0]         r_valid;
   logic [TAG_W-1:0]         r_snoop_tag [LINES];

   logic [IDX_W-1:0]  w_core_idx, w_req_idx, w_inv_idx;
   logic [TAG_W-1:0]  w_req_tag, w_inv_tag, w_tag_rdata;
   logic [LINE_W-1:0] w_data_rdata;
   logic [LINES-1:0]  w_clr, w_set;
   logic              w_rd_en, w_hit, w_inv_match, w_inv_fill, w_fill_we;
   logic              w_ack_next, w_hit_load, w_miss, w_fill_done;
   logic              w_unused;

   assign w_core_idx = i_core_addr[TAG_LO-1:OFFSET_W];
   assign w_req_idx  = r_line_addr[TAG_LO-1:OFFSET_W];
   assign w_req_tag  = r_line_addr[ADDR_W-1:TAG_LO];
   assign w_inv_idx  = i_inv_addr[TAG_LO-1:OFFSET_W];
   assign w_inv_tag  = i_inv_addr[ADDR_W-1:TAG_LO];
   assign w_unused   = &{1'b0, i_core_addr[OFFSET_W-1:0], i_inv_addr[OFFSET_W-1:0]};

   assign w_rd_en = (r_state == ST_IDLE) & i_core_req;

   // The RAM tag port is busy with fetch lookups, so a flop copy of the tags serves invalidate snoops.
   assign w_inv_match = i_inv & r_valid[w_inv_idx] & (r_snoop_tag[w_inv_idx] == w_inv_tag);
   assign w_inv_fill  = i_inv & (i_inv_addr[ADDR_W-1:OFFSET_W] == r_line_addr);

   always_comb begin
      w_clr = '0;
      if (i_flush) begin
         w_clr = '1;
      end else if (w_inv_match) begin
         w_clr[w_inv_idx] = 1'b1;
      end
   end

   // Lookup sees this cycle's invalidates, so a line cleared during LOOKUP already misses.
   assign w_hit = r_cacheable & r_valid[w_req_idx] & ~w_clr[w_req_idx] & (w_tag_rdata == w_req_tag);

   assign w_fill_we = w_fill_done & r_cacheable & ~r_poison & ~w_inv_fill & ~w_clr[w_req_idx];

   always_comb begin
      w_set = '0;
      if (w_fill_we) begin
         w_set[w_req_idx] = 1'b1;
      end
   end

   insn_line_cache_sdp_ram #(
      .DEPTH  (LINES),
      .DATA_W (TAG_W)
   ) u_tag_ram (
      .CLK     (CLK),
      .i_we    (w_fill_we),
      .i_waddr (w_req_idx),
      .i_wdata (w_req_tag),
      .i_re    (w_rd_en),
      .i_raddr (w_core_idx),
      .o_rdata (w_tag_rdata)
   );

   insn_line_cache_sdp_ram #(
      .DEPTH  (LINES),
      .DATA_W (LINE_W)
   ) u_data_ram (
      .CLK     (CLK),
      .i_we    (w_fill_we),
      .i_waddr (w_req_idx),
      .i_wdata (i_mem_data),
      .i_re    (w_rd_en),
      .i_raddr (w_core_idx),
      .o_rdata (w_data_rdata)
   );

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_state_next = r_state;
      w_ack_next   = 1'b0;
      w_hit_load   = 1'b0;
      w_miss       = 1'b0;
      w_fill_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_core_req) begin
               w_state_next = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (w_hit) begin
               w_state_next = ST_RESP;
               w_ack_next   = 1'b1;
               w_hit_load   = 1'b1;
            end else begin
               w_state_next = ST_FILL;
               w_miss       = 1'b1;
            end
         end
         ST_FILL: begin
            if (i_mem_ack) begin
               w_state_next = ST_RESP;
               w_ack_next   = 1'b1;
               w_fill_done  = 1'b1;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_line_addr <= '0;
         r_cacheable <= 1'b0;
         r_poison    <= 1'b0;
         o_core_ack  <= 1'b0;
         o_core_data <= '0;
         o_mem_req   <= 1'b0;
         o_mem_addr  <= '0;
      end else begin
         o_core_ack <= w_ack_next;
         if (w_rd_en) begin
            r_line_addr <= i_core_addr[ADDR_W-1:OFFSET_W];
            r_cacheable <= i_cacheable;
         end
         if (w_hit_load) begin
            o_core_data <= w_data_rdata;
         end else if (w_fill_done) begin
            o_core_data <= i_mem_data;
         end
         if (w_miss) begin
            o_mem_req  <= 1'b1;
            o_mem_addr <= {r_line_addr, {OFFSET_W{1'b0}}};
         end else if (w_fill_done) begin
            o_mem_req  <= 1'b0;
         end
         // Poison outlives the fill only until the response has gone out.
         if (r_state == ST_RESP) begin
            r_poison <= 1'b0;
         end else if ((r_state == ST_FILL) && (i_flush || w_inv_fill)) begin
            r_poison <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_valid <= '0;
      end else begin
         r_valid <= (r_valid | w_set) & ~w_clr;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_fill_we) begin
         r_snoop_tag[w_req_idx] <= w_req_tag;
      end
   end

endmodule

// File: tb/tb_insn_line_cache.sv
// Self-checking bench for insn_line_cache: directed scenarios plus randomized fetch traffic
// against a line-level reference model of the cache contents.
module tb_insn_line_cache;

   localparam int EV_NONE  = 0;
   localparam int EV_INV   = 1;
   localparam int EV_FLUSH = 2;

   logic         CLK;
   logic         RST_X;
   logic         i_core_req;
   logic [31:0]  i_core_addr;
   logic         i_cacheable;
   logic         o_core_ack;
   logic [127:0] o_core_data;
   logic         o_mem_req;
   logic [31:0]  o_mem_addr;
   logic         i_mem_ack;
   logic [127:0] i_mem_data;
   logic         i_inv;
   logic [31:0]  i_inv_addr;
   logic         i_flush;

   int n_pass = 0;
   int n_fail = 0;

   // Reference model: what each of the 16 direct-mapped slots currently holds.
   bit           m_valid [16];
   logic [23:0]  m_tag   [16];
   logic [127:0] m_data  [16];

   insn_line_cache #(
      .LINES  (16),
      .ADDR_W (32)
   ) dut (
      .CLK         (CLK),
      .RST_X       (RST_X),
      .i_core_req  (i_core_req),
      .i_core_addr (i_core_addr),
      .i_cacheable (i_cacheable),
      .o_core_ack  (o_core_ack),
      .o_core_data (o_core_data),
      .o_mem_req   (o_mem_req),
      .o_mem_addr  (o_mem_addr),
      .i_mem_ack   (i_mem_ack),
      .i_mem_data  (i_mem_data),
      .i_inv       (i_inv),
      .i_inv_addr  (i_inv_addr),
      .i_flush     (i_flush)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mdl_clear_all();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   task automatic mdl_event(input int kind, input logic [31:0] a, output bit present);
      logic [3:0] ix;
      ix = a[7:4];
      present = 1'b0;
      if (kind == EV_FLUSH) begin
         mdl_clear_all();
      end else if (kind == EV_INV) begin
         present = m_valid[ix] && (m_tag[ix] == a[31:8]);
         if (present) m_valid[ix] = 1'b0;
      end
   endtask

   // One fetch from request to the idle cycle after the ack. The memory answers lat cycles after
   // o_mem_req first shows; an optional inv/flush pulse is sampled at relative edge ev_cyc (request edge = 0).
   task automatic fetch(input logic [31:0] addr, input bit cach, input int lat, input int ev_kind,
                        input logic [31:0] ev_addr, input int ev_cyc, input logic [127:0] mdata);
      logic [3:0]  idx;
      logic [23:0] tg;
      bit          hit, poison, fired, present;
      int          ack_edge;
      idx = addr[7:4];
      tg = addr[31:8];
      poison = 1'b0;
      ack_edge = -1;
      i_core_req = 1'b1;
      i_core_addr = addr;
      i_cacheable = cach;
      for (int r = 0; r <= lat + 1; r++) begin
         fired = (ev_kind != EV_NONE) && (r == ev_cyc);
         i_inv = fired && (ev_kind == EV_INV);
         i_flush = fired && (ev_kind == EV_FLUSH);
         i_inv_addr = ev_addr;
         i_mem_ack = (r == ack_edge);
         i_mem_data = (r == ack_edge) ? mdata : 128'h0;
         @(posedge CLK);
         #1;
         i_inv = 1'b0;
         i_flush = 1'b0;
         i_mem_ack = 1'b0;
         if (fired) begin
            mdl_event(ev_kind, ev_addr, present);
            if (r >= 2) begin
               if (ev_kind == EV_FLUSH || ev_addr[31:4] == addr[31:4]) poison = 1'b1;
               if (r == ack_edge && present && ev_addr[7:4] == idx) poison = 1'b1;
            end
         end
         if (r == 0) begin
            check("accept_ack", o_core_ack, 0);
            check("accept_memreq", o_mem_req, 0);
         end else if (r == 1) begin
            hit = cach && m_valid[idx] && (m_tag[idx] == tg);
            if (hit) begin
               check("hit_ack", o_core_ack, 1);
               check("hit_data", o_core_data, m_data[idx]);
               check("hit_memreq", o_mem_req, 0);
               break;
            end
            check("miss_memreq", o_mem_req, 1);
            check("miss_memaddr", o_mem_addr, {addr[31:4], 4'h0});
            check("miss_noack", o_core_ack, 0);
            ack_edge = 1 + lat;
         end else if (r < ack_edge) begin
            check("fill_memreq_held", o_mem_req, 1);
            check("fill_noack", o_core_ack, 0);
         end else begin
            check("fill_ack", o_core_ack, 1);
            check("fill_data", o_core_data, mdata);
            check("fill_memreq_drop", o_mem_req, 0);
            if (cach && !poison) begin
               m_valid[idx] = 1'b1;
               m_tag[idx] = tg;
               m_data[idx] = mdata;
            end
         end
      end
      i_core_req = 1'b0;
      i_mem_data = 128'h0;
      @(posedge CLK);
      #1;
      check("ack_one_cycle", o_core_ack, 0);
   endtask

   task automatic simple(input logic [31:0] addr, input bit cach, input logic [127:0] mdata);
      fetch(addr, cach, 2, EV_NONE, 32'h0, 0, mdata);
   endtask

   task automatic pulse(input int kind, input logic [31:0] a);
      bit present;
      i_inv = (kind == EV_INV);
      i_flush = (kind == EV_FLUSH);
      i_inv_addr = a;
      @(posedge CLK);
      #1;
      i_inv = 1'b0;
      i_flush = 1'b0;
      mdl_event(kind, a, present);
   endtask

   task automatic expect_miss(input string tag, input logic [31:0] addr);
      check(tag, {31'h0, m_valid[addr[7:4]] && m_tag[addr[7:4]] == addr[31:8]}, 0);
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = 32'h8000_0000;
      a[8] = 1'($urandom_range(0, 1));
      a[5:4] = 2'($urandom_range(0, 3));
      a[3:0] = 4'($urandom_range(0, 15));
      return a;
   endfunction

   initial begin
      logic [127:0] d_a5;
      d_a5 = {16{8'hA5}};
      RST_X = 1'b0;
      i_core_req = 1'b0;
      i_core_addr = 32'h0;
      i_cacheable = 1'b0;
      i_mem_ack = 1'b0;
      i_mem_data = 128'h0;
      i_inv = 1'b0;
      i_inv_addr = 32'h0;
      i_flush = 1'b0;
      mdl_clear_all();

      repeat (3) @(posedge CLK);
      #1;
      check("rst_core_ack", o_core_ack, 0);
      check("rst_core_data", o_core_data, 0);
      check("rst_mem_req", o_mem_req, 0);
      check("rst_mem_addr", o_mem_addr, 0);
      @(negedge CLK);
      RST_X = 1'b1;
      @(posedge CLK);
      #1;

      // Cold miss with ack at N+5, then a hit on another word of the same line.
      fetch(32'h8000_0010, 1'b1, 4, EV_NONE, 32'h0, 0, d_a5);
      fetch(32'h8000_001C, 1'b1, 3, EV_NONE, 32'h0, 0, 128'h0);

      // Conflict on index 1 evicts the first line.
      simple(32'h8000_0110, 1'b1, rnd_line());
      expect_miss("conflict_evicted", 32'h8000_0010);
      simple(32'h8000_0010, 1'b1, rnd_line());

      // Invalidate while idle, then invalidate the line being filled (mid-fill and on the ack edge).
      pulse(EV_INV, 32'h8000_0014);
      expect_miss("inv_cleared", 32'h8000_0010);
      simple(32'h8000_0010, 1'b1, rnd_line());
      fetch(32'h8000_0020, 1'b1, 4, EV_INV, 32'h8000_0028, 3, rnd_line());
      simple(32'h8000_0020, 1'b1, rnd_line());
      fetch(32'h8000_0030, 1'b1, 3, EV_INV, 32'h8000_0030, 4, rnd_line());
      simple(32'h8000_0030, 1'b1, rnd_line());

      // Flush after filling indices 0..2; flush during LOOKUP of a hit.
      simple(32'h8000_0000, 1'b1, rnd_line());
      simple(32'h8000_0010, 1'b1, rnd_line());
      simple(32'h8000_0020, 1'b1, rnd_line());
      pulse(EV_FLUSH, 32'h0);
      simple(32'h8000_0000, 1'b1, rnd_line());
      simple(32'h8000_0010, 1'b1, rnd_line());
      simple(32'h8000_0020, 1'b1, rnd_line());
      fetch(32'h8000_0024, 1'b1, 2, EV_FLUSH, 32'h0, 1, rnd_line());

      // Bypass: two fills, and a cached copy of the same line is left alone.
      simple(32'h9000_0040, 1'b0, rnd_line());
      simple(32'h9000_0040, 1'b0, rnd_line());
      simple(32'h8000_0040, 1'b1, rnd_line());
      simple(32'h8000_0040, 1'b0, rnd_line());
      simple(32'h8000_0040, 1'b1, rnd_line());

      // Reset in the middle of a fill.
      i_core_req = 1'b1;
      i_core_addr = 32'h8000_0050;
      i_cacheable = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      check("pre_reset_memreq", o_mem_req, 1);
      #2;
      RST_X = 1'b0;
      #1;
      check("reset_memreq_drop", o_mem_req, 0);
      check("reset_memaddr", o_mem_addr, 0);
      check("reset_data", o_core_data, 0);
      i_core_req = 1'b0;
      mdl_clear_all();
      @(negedge CLK);
      RST_X = 1'b1;
      @(posedge CLK);
      #1;
      simple(32'h8000_0040, 1'b1, rnd_line());

      // Randomized traffic over 8 lines sharing 4 indices, with invalidates and flushes mixed in.
      for (int n = 0; n < 300; n++) begin
         int lat, sel, kind, ev_cyc;
         lat = $urandom_range(1, 5);
         sel = $urandom_range(0, 9);
         kind = (sel < 7) ? EV_NONE : ((sel < 9) ? EV_INV : EV_FLUSH);
         ev_cyc = $urandom_range(0, lat + 1);
         fetch(rnd_addr(), ($urandom_range(0, 9) != 0), lat, kind, rnd_addr(), ev_cyc, rnd_line());
      end

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
